argmax_frame_ctrl: RTL and testbench
====================================

# argmax_frame_ctrl

Frame-level controller for the final classification stage. It accepts one start pulse per inference, then takes exactly NUM_CLASSES class scores through a valid/ready stream and tracks the running maximum. It returns the winning class index and score through a valid/ready result port. It sits between the last fully-connected layer's output stream and the host/result interface, and makes each argmax pass explicitly framed and restartable.

## Interface
- NUM_CLASSES, 1000: scores per frame; legal range 2..1024.
- DW, 16: score width, signed two's complement.
- IW, 10: index width, with 2^IW >= NUM_CLASSES.
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-low.
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE, or in DONE on the cycle the result handshake completes.
- abort  in  1  drops the current frame and returns to IDLE; no result is produced.
- s_valid  in  1  score beat valid.
- s_ready  out  1  controller accepts a beat.
- s_data  in  DW  class score.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_index  out  IW  argmax class index.
- m_score  out  DW  maximum score.
- busy  out  1  high in SCAN or DONE.

## Operation
- States:
  - IDLE: s_ready=0, m_valid=0.
  - SCAN: s_ready=1.
  - DONE: m_valid=1, s_ready=0.
- IDLE → SCAN when start=1. The beat counter cnt and the max registers clear on that edge.
- In SCAN, each beat with s_valid&&s_ready is accepted:
  - Beat 0 loads max=s_data and idx=0 unconditionally. There is no comparison against a reset value, so all-negative frames are handled correctly.
  - Beat k>0 updates when s_data > max, using a signed, strict comparison.
  - On ties, the earliest index wins.
  - cnt increments on every accepted beat.
- SCAN → DONE on the accepted beat with cnt==NUM_CLASSES-1. That beat's comparison is included in the result.
- DONE → IDLE on m_valid&&m_ready. If start=1 on the same cycle, go DONE → SCAN directly, with the same clearing as IDLE → SCAN.
- start in SCAN, or in DONE without the handshake: ignored, no side effects.
- abort in SCAN or DONE → IDLE next edge; max, idx and cnt are cleared. abort has priority over start and over the result handshake. abort in IDLE has no effect.
- m_index and m_score are stable while m_valid=1. Outside DONE they hold their last values; they are not required to be zero.
- Arithmetic: cnt is IW bits wide and never wraps, because the frame ends at NUM_CLASSES-1. No saturation or overflow is possible, since only comparisons are performed.

## Timing
- Reset values: state=IDLE, s_ready=0, m_valid=0, busy=0, m_index=0, m_score=0, cnt=0.
- Reset asserted mid-frame behaves like abort, but acts immediately.
- start→s_ready: 1 cycle (s_ready registered from state).
- Last beat accepted at edge t → m_valid=1 from edge t; the result is visible in the following cycle. No additional pipeline.
- Throughput: 1 beat/cycle, with s_valid gaps allowed anywhere.
- Minimum frame period is NUM_CLASSES+1 cycles with back-to-back start at the handshake.
- s_ready is a function of state only and has no combinational path from s_valid. m_valid has no path from m_ready.

## Structure
- Package argmax_pkg holds:
  - typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t.
  - Default constants for NUM_CLASSES, DW and IW.
- Sub-module argmax_core holds the running-max datapath:
  - Inputs: clr, load_first, en, data.
  - Outputs: max, idx.
  - Contains the comparator, the max/idx registers and the beat counter.
- The top level holds the FSM and the handshake logic only.

## Test plan
- Basic frame: NUM_CLASSES=8, scores 3,9,-2,9,5,0,1,7 → m_index=1, m_score=9, on the cycle after beat 7 (earliest index wins the tie).
- All-negative frame: scores -5,-3,-8,-3,-9,-7,-6,-4 → m_index=1, m_score=-3 (first-beat load, no compare against 0).
- Backpressure and gaps: random s_valid gaps, m_ready held 0 for 5 cycles → m_valid stays high with m_index/m_score stable, and s_ready=0 throughout DONE.
- Back-to-back frames: start asserted with the DONE handshake → next frame accepted with s_ready=1 on the following cycle and no result leakage; second frame max at index 7=100 → m_index=7.
- Abort and spurious start: abort after beat 4 → IDLE, m_valid never asserts; a new frame is then correct. start pulsed mid-SCAN is ignored, and the count is unaffected.
- Reset mid-frame: rst low at beat 3 → all outputs at reset values immediately; the next full frame is correct.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared types and default sizing for the argmax frame controller.
// Contents:
//   argmax_state_t  - frame FSM state encoding (IDLE, SCAN, DONE)
//   *_DEF           - default NUM_CLASSES / DW / IW used by the RTL parameters
package argmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_t;

    localparam int NUM_CLASSES_DEF = 1000;  // scores per frame, legal 2..1024
    localparam int DW_DEF          = 16;    // signed score width
    localparam int IW_DEF          = 10;    // index width, 2**IW >= NUM_CLASSES

endpackage

// File: rtl/argmax_frame_ctrl_if.sv
// Score stream and result port of the argmax frame controller.
// Signals:
//   s_valid/s_ready/s_data    - score beats from the last FC layer
//   m_valid/m_ready           - result handshake towards the host
//   m_index/m_score           - winning class index and its score
// Modports:
//   slave  - the controller's view (consumes scores, produces the result)
//   master - the environment's view (produces scores, consumes the result)
interface argmax_frame_ctrl_if
    import argmax_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF
);

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [IW-1:0] m_index;
    logic [DW-1:0] m_score;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_index, m_score
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_index, m_score
    );

endinterface

// File: rtl/argmax_core.sv
// Running-maximum datapath: comparator, max/idx registers and beat counter.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   clr         - zero max, idx and cnt (frame start / abort); wins over en
//   load_first  - current beat is beat 0: load it without comparing
//   en          - a beat is accepted this cycle
//   data        - signed score of the accepted beat
//   max, idx    - running maximum and the index where it was first seen
//   cnt         - number of beats accepted so far in this frame
module argmax_core
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DW          = DW_DEF,
    parameter int IW          = IW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load_first,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] max,
    output logic [IW-1:0] idx,
    output logic [IW-1:0] cnt
);

    localparam logic [IW-1:0] LAST_CNT = IW'(NUM_CLASSES - 1);

    logic [DW-1:0] max_q, max_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal gets a hold default before any branch, so no path leaves it unassigned and no latch is inferred.
        max_d = max_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (clr) begin
            max_d = '0;
            idx_d = '0;
            cnt_d = '0;
        end else if (en) begin
            // Strict greater-than keeps the earliest index on ties.
            if (load_first || ($signed(data) > $signed(max_q))) begin
                max_d = data;
                idx_d = cnt_q;
            end
            // The counter parks on the last index instead of wrapping; the
            // next frame start clears it.
            if (cnt_q != LAST_CNT) begin
                cnt_d = cnt_q + IW'(1);
            end
        end
    end

    // NOTE: these registers drive result outputs that have defined reset values, so they are reset; a pure data buffer would not need it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            max_q <= max_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign max = max_q;
    assign idx = idx_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/argmax_frame_ctrl.sv
// Frame-level argmax controller: one start per inference, exactly
// NUM_CLASSES scores in, one {index, score} result out.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   start     - begin a frame (IDLE, or DONE on the result handshake cycle)
//   abort     - drop the current frame, no result; beats start and handshake
//   busy      - high in SCAN or DONE
//   bus       - score stream and result port (slave modport)
module argmax_frame_ctrl
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DW          = DW_DEF,
    parameter int IW          = IW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    argmax_frame_ctrl_if.slave  bus
);

    localparam logic [IW-1:0] LAST_CNT = IW'(NUM_CLASSES - 1);

    argmax_state_t state_q, state_d;

    logic          clr;
    logic          accept;
    logic          load_first;
    logic [IW-1:0] cnt;
    logic [IW-1:0] idx_val;
    logic [DW-1:0] max_val;

    // A beat coinciding with abort is dropped; the frame is discarded anyway.
    assign accept     = (state_q == SCAN) && bus.s_valid && !abort;
    assign load_first = (cnt == '0);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    clr     = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (accept && (cnt == LAST_CNT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (bus.m_ready) begin
                    // Back-to-back frames: restart straight from the handshake.
                    if (start) begin
                        state_d = SCAN;
                        clr     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    argmax_core #(
        .NUM_CLASSES (NUM_CLASSES),
        .DW          (DW),
        .IW          (IW)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load_first (load_first),
        .en         (accept),
        .data       (bus.s_data),
        .max        (max_val),
        .idx        (idx_val),
        .cnt        (cnt)
    );

    // Handshake outputs decode the state register only: no path from
    // s_valid to s_ready, nor from m_ready to m_valid.
    assign bus.s_ready = (state_q == SCAN);
    assign bus.m_valid = (state_q == DONE);
    assign busy        = (state_q == SCAN) || (state_q == DONE);
    assign bus.m_index = idx_val;
    assign bus.m_score = max_val;

endmodule

// File: tb/tb_argmax_frame_ctrl.sv
// Self-checking bench for argmax_frame_ctrl with an 8-class frame.
// Table-driven frames plus hand-written corner sequences; expected results
// are queued when a frame is driven and compared when the DUT hands them out.
module tb_argmax_frame_ctrl;
    import argmax_pkg::*;

    localparam int NC = 8;
    localparam int DW = 16;
    localparam int IW = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;

    argmax_frame_ctrl_if #(.DW(DW), .IW(IW)) bus ();

    argmax_frame_ctrl #(
        .NUM_CLASSES (NC),
        .DW          (DW),
        .IW          (IW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int scores [NC];
        int exp_idx;
        int exp_score;
    } vec_t;

    typedef struct {
        int idx;
        int score;
    } res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb_q[$];
    res_t mon_e;
    vec_t vecs[6];

    task automatic check(input string name, input integer act, input integer exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor, sampled mid-cycle: any result with nothing queued is a
    // leak; a handshake pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (rst && (bus.m_valid === 1'b1)) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got m_valid=1 idx=%0d, expected no result",
                         bus.m_index);
            end else if (bus.m_ready === 1'b1) begin
                mon_e = sb_q.pop_front();
                check("m_index", integer'(bus.m_index), mon_e.idx);
                check("m_score", integer'($signed(bus.m_score)), mon_e.score);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Holds one beat until accepted; s_ready only moves at edges, so the
    // value seen now is what the next edge samples.
    task automatic send_beat(input int d);
        int budget = 20;
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(d);
        while (bus.s_ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: got s_ready=%b, expected 1", bus.s_ready);
        end
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic send_beats(input int s[NC], input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_beat(s[i]);
        end
    endtask

    task automatic wait_result();
        int budget = 20;
        bus.m_ready = 1'b1;
        while (bus.m_valid !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL result_timeout: got m_valid=%b, expected 1", bus.m_valid);
        end
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic push_exp(input int idx, input int score);
        res_t r;
        r.idx   = idx;
        r.score = score;
        sb_q.push_back(r);
    endtask

    task automatic run_frame(input vec_t v, input bit gaps);
        push_exp(v.exp_idx, v.exp_score);
        pulse_start();
        check("s_ready_after_start", integer'(bus.s_ready), 1);
        send_beats(v.scores, 0, NC - 1, gaps);
        check("m_valid_after_last", integer'(bus.m_valid), 1);
        check("s_ready_in_done", integer'(bus.s_ready), 0);
        wait_result();
        check("busy_after_handshake", integer'(busy), 0);
    endtask

    initial begin
        vec_t v;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        vecs[0].scores = '{3, 9, -2, 9, 5, 0, 1, 7};
        vecs[0].exp_idx = 1;  vecs[0].exp_score = 9;
        vecs[1].scores = '{-5, -3, -8, -3, -9, -7, -6, -4};
        vecs[1].exp_idx = 1;  vecs[1].exp_score = -3;
        vecs[2].scores = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[2].exp_idx = 7;  vecs[2].exp_score = 8;
        vecs[3].scores = '{4, 4, 4, 4, 4, 4, 4, 4};
        vecs[3].exp_idx = 0;  vecs[3].exp_score = 4;
        vecs[4].scores = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767};
        vecs[4].exp_idx = 7;  vecs[4].exp_score = -32767;
        vecs[5].scores = '{32767, 0, -1, 32767, -32768, 1, 2, 32767};
        vecs[5].exp_idx = 0;  vecs[5].exp_score = 32767;

        // Reset state.
        repeat (2) tick();
        check("rst_s_ready", integer'(bus.s_ready), 0);
        check("rst_m_valid", integer'(bus.m_valid), 0);
        check("rst_busy", integer'(busy), 0);
        check("rst_m_index", integer'(bus.m_index), 0);
        check("rst_m_score", integer'(bus.m_score), 0);
        rst = 1'b1;
        tick();

        // Table-driven frames, alternating dense and gapped streams.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], i[0]);
        end

        // Backpressure: result held for 5 cycles with m_ready low.
        v.scores = '{10, 20, -1, 20, 30, 30, 2, -7};
        push_exp(4, 30);
        pulse_start();
        send_beats(v.scores, 0, NC - 1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("bp_m_valid", integer'(bus.m_valid), 1);
            check("bp_s_ready", integer'(bus.s_ready), 0);
            check("bp_m_index", integer'(bus.m_index), 4);
            check("bp_m_score", integer'($signed(bus.m_score)), 30);
            tick();
        end
        wait_result();

        // Back-to-back: start together with the result handshake.
        run_frame(vecs[0], 1'b0);
        push_exp(1, 9);
        pulse_start();
        send_beats(vecs[0].scores, 0, NC - 1, 1'b0);
        check("b2b_m_valid", integer'(bus.m_valid), 1);
        v.scores = '{5, 6, 7, 8, 9, 10, 11, 100};
        bus.m_ready = 1'b1;
        start = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        start = 1'b0;
        check("b2b_s_ready", integer'(bus.s_ready), 1);
        check("b2b_m_valid_low", integer'(bus.m_valid), 0);
        check("b2b_busy", integer'(busy), 1);
        push_exp(7, 100);
        send_beats(v.scores, 0, NC - 1, 1'b0);
        check("b2b2_m_valid", integer'(bus.m_valid), 1);
        wait_result();

        // Abort after beat 4: no result, registers cleared, next frame good.
        v.scores = '{50, 60, 70, 80, 90, 1, 2, 3};
        pulse_start();
        send_beats(v.scores, 0, 4, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", integer'(busy), 0);
        check("abort_s_ready", integer'(bus.s_ready), 0);
        check("abort_m_index", integer'(bus.m_index), 0);
        check("abort_m_score", integer'(bus.m_score), 0);
        repeat (3) tick();
        check("abort_m_valid", integer'(bus.m_valid), 0);
        run_frame(vecs[2], 1'b0);

        // Spurious start mid-SCAN: ignored, count continues.
        v.scores = '{-1, 42, 3, 4, 5, 6, 7, 8};
        push_exp(1, 42);
        pulse_start();
        send_beats(v.scores, 0, 2, 1'b0);
        pulse_start();
        check("spur_busy", integer'(busy), 1);
        send_beats(v.scores, 3, NC - 1, 1'b0);
        check("spur_m_valid", integer'(bus.m_valid), 1);
        wait_result();

        // Reset mid-frame: outputs reset immediately, next frame correct.
        pulse_start();
        send_beats(vecs[5].scores, 0, 2, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'sd77;
        rst = 1'b0;
        #1;
        check("mrst_s_ready", integer'(bus.s_ready), 0);
        check("mrst_busy", integer'(busy), 0);
        check("mrst_m_index", integer'(bus.m_index), 0);
        check("mrst_m_score", integer'(bus.m_score), 0);
        bus.s_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_frame(vecs[1], 1'b1);

        repeat (2) tick();
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1);
    end

endmodule
